// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - byte-serial instruction fetch with one-deep issue register
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   mem_req, mem_addr     instruction-memory read request and address (current PC)
//   mem_ack, mem_rdata    read data valid strobe and instruction byte
//   pc_load, pc_target    redirect strobe and redirect address
//   issue_valid/ready     issue handshake towards the control unit / datapath
//   opCode, operand       high / low nibble of the first instruction byte
//   imm                   immediate byte (8'h00 for one-byte instructions)
//   pc_out                address of the first byte of the issued instruction
module instruction_fetch_unit (
    input  logic       clk,
    input  logic       rst_n,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic       pc_load,
    input  logic [7:0] pc_target,
    output logic       issue_valid,
    input  logic       issue_ready,
    output logic [3:0] opCode,
    output logic [3:0] operand,
    output logic [7:0] imm,
    output logic [7:0] pc_out
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        ISSUE     = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] pc;
    logic       two_byte;

    // Opcodes 4'b10xx carry an immediate byte.
    assign two_byte = (mem_rdata[7:6] == 2'b10);

    always_comb begin
        next_state = state;
        case (state)
            FETCH_OP:  if (mem_ack) next_state = two_byte ? FETCH_IMM : ISSUE;
            FETCH_IMM: if (mem_ack) next_state = ISSUE;
            ISSUE:     if (issue_ready) next_state = FETCH_OP;
            default:   next_state = FETCH_OP;
        endcase
        // A redirect always restarts fetching, whatever the handshake was doing.
        if (pc_load) next_state = FETCH_OP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH_OP;
        else        state <= next_state;
    end

    // Gate with rst_n so nothing is requested or issued while reset is held.
    assign mem_req     = rst_n && (state != ISSUE);
    assign issue_valid = rst_n && (state == ISSUE);
    assign mem_addr    = pc;

    // Instruction registers only move on a completed, non-redirected fetch edge,
    // so a redirect discards the byte in flight and an issued instruction holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= 8'h00;
            opCode  <= 4'h0;
            operand <= 4'h0;
            imm     <= 8'h00;
            pc_out  <= 8'h00;
        end else if (pc_load) begin
            pc <= pc_target;
        end else if (state == FETCH_OP && mem_ack) begin
            opCode  <= mem_rdata[7:4];
            operand <= mem_rdata[3:0];
            imm     <= 8'h00;
            pc_out  <= pc;
            pc      <= pc + 8'h01;
        end else if (state == FETCH_IMM && mem_ack) begin
            imm <= mem_rdata;
            pc  <= pc + 8'h01;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vector bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       pc_load;
    logic [7:0] pc_target;
    logic       issue_valid;
    logic       issue_ready;
    logic [3:0] opCode;
    logic [3:0] operand;
    logic [7:0] imm;
    logic [7:0] pc_out;

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .opCode      (opCode),
        .operand     (operand),
        .imm         (imm),
        .pc_out      (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per cycle: inputs driven for the cycle, outputs expected
    // during that cycle (before the next rising edge).
    typedef struct {
        logic       r;
        logic       a;
        logic [7:0] d;
        logic       l;
        logic [7:0] t;
        logic       y;
        logic       e_req;
        logic [7:0] e_addr;
        logic       e_iv;
        logic [3:0] e_op;
        logic [3:0] e_opd;
        logic [7:0] e_imm;
        logic [7:0] e_pco;
    } vec_t;

    vec_t vq[$];
    int   checks;
    int   errors;
    logic [7:0] mem [256];

    task automatic add(input logic r, input logic a, input logic [7:0] d, input logic l,
                       input logic [7:0] t, input logic y, input logic e_req,
                       input logic [7:0] e_addr, input logic e_iv, input logic [3:0] e_op,
                       input logic [3:0] e_opd, input logic [7:0] e_imm, input logic [7:0] e_pco);
        vec_t v;
        v = '{r, a, d, l, t, y, e_req, e_addr, e_iv, e_op, e_opd, e_imm, e_pco};
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    int         iss_cyc [3];
    logic [7:0] iss_pco [3];
    logic [7:0] iss_imm [3];
    int         n_iss;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; pc_load = 1'b0;
        pc_target = 8'h00; issue_ready = 1'b0;

        //   r a  rdata l  tgt   y    req addr  iv op    opd   imm    pco
        add(O, I, 8'hFF, I, 8'h55, I,  O, 8'h00, O, 4'h0, 4'h0, 8'h00, 8'h00); // reset wins
        add(I, I, 8'h35, O, 8'h00, I,  I, 8'h00, O, 4'h0, 4'h0, 8'h00, 8'h00); // 1-byte fetch
        add(I, I, 8'h00, O, 8'h00, I,  O, 8'h01, I, 4'h3, 4'h5, 8'h00, 8'h00); // issue
        add(I, I, 8'h92, O, 8'h00, I,  I, 8'h01, O, 4'h3, 4'h5, 8'h00, 8'h00); // 2-byte op
        add(I, I, 8'h7E, O, 8'h00, I,  I, 8'h02, O, 4'h9, 4'h2, 8'h00, 8'h01); // immediate
        add(I, O, 8'h00, O, 8'h00, O,  O, 8'h03, I, 4'h9, 4'h2, 8'h7E, 8'h01); // backpressure
        add(I, I, 8'hAA, O, 8'h00, O,  O, 8'h03, I, 4'h9, 4'h2, 8'h7E, 8'h01);
        add(I, O, 8'h00, O, 8'h00, O,  O, 8'h03, I, 4'h9, 4'h2, 8'h7E, 8'h01);
        add(I, O, 8'h00, O, 8'h00, O,  O, 8'h03, I, 4'h9, 4'h2, 8'h7E, 8'h01);
        add(I, O, 8'h00, O, 8'h00, I,  O, 8'h03, I, 4'h9, 4'h2, 8'h7E, 8'h01); // release
        add(I, O, 8'h11, O, 8'h00, I,  I, 8'h03, O, 4'h9, 4'h2, 8'h7E, 8'h01); // wait states
        add(I, O, 8'h11, O, 8'h00, I,  I, 8'h03, O, 4'h9, 4'h2, 8'h7E, 8'h01);
        add(I, O, 8'h11, O, 8'h00, I,  I, 8'h03, O, 4'h9, 4'h2, 8'h7E, 8'h01);
        add(I, I, 8'h11, O, 8'h00, I,  I, 8'h03, O, 4'h9, 4'h2, 8'h7E, 8'h01); // first ack
        add(I, I, 8'h00, O, 8'h00, I,  O, 8'h04, I, 4'h1, 4'h1, 8'h00, 8'h03);
        add(I, I, 8'hA7, O, 8'h00, I,  I, 8'h04, O, 4'h1, 4'h1, 8'h00, 8'h03);
        add(I, I, 8'h33, I, 8'h40, I,  I, 8'h05, O, 4'hA, 4'h7, 8'h00, 8'h04); // redirect in FETCH_IMM
        add(I, I, 8'hC2, O, 8'h00, I,  I, 8'h40, O, 4'hA, 4'h7, 8'h00, 8'h04);
        add(I, O, 8'h00, I, 8'h80, O,  O, 8'h41, I, 4'hC, 4'h2, 8'h00, 8'h40); // drop pending
        add(I, I, 8'hB5, O, 8'h00, I,  I, 8'h80, O, 4'hC, 4'h2, 8'h00, 8'h40);
        add(I, O, 8'h00, O, 8'h00, I,  I, 8'h81, O, 4'hB, 4'h5, 8'h00, 8'h80);
        add(I, I, 8'h9C, O, 8'h00, I,  I, 8'h81, O, 4'hB, 4'h5, 8'h00, 8'h80);
        add(I, O, 8'h00, I, 8'hFF, I,  O, 8'h82, I, 4'hB, 4'h5, 8'h9C, 8'h80); // redirect + accept
        add(I, I, 8'h8D, O, 8'h00, I,  I, 8'hFF, O, 4'hB, 4'h5, 8'h9C, 8'h80); // op at FF
        add(I, I, 8'h44, O, 8'h00, I,  I, 8'h00, O, 4'h8, 4'hD, 8'h00, 8'hFF); // imm at 00
        add(I, O, 8'h00, O, 8'h00, O,  O, 8'h01, I, 4'h8, 4'hD, 8'h44, 8'hFF);
        add(O, O, 8'h00, O, 8'h00, I,  O, 8'h01, O, 4'h8, 4'hD, 8'h44, 8'hFF); // reset in ISSUE
        add(I, I, 8'h35, I, 8'h10, O,  I, 8'h00, O, 4'h0, 4'h0, 8'h00, 8'h00); // redirect in FETCH_OP
        add(I, O, 8'h00, O, 8'h00, O,  I, 8'h10, O, 4'h0, 4'h0, 8'h00, 8'h00);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst_n = vq[i].r; mem_ack = vq[i].a; mem_rdata = vq[i].d;
            pc_load = vq[i].l; pc_target = vq[i].t; issue_ready = vq[i].y;
            #1;
            check($sformatf("vec%0d", i),
                  {30'd0, mem_req, mem_addr, issue_valid, opCode, operand, imm, pc_out},
                  {30'd0, vq[i].e_req, vq[i].e_addr, vq[i].e_iv, vq[i].e_op, vq[i].e_opd,
                   vq[i].e_imm, vq[i].e_pco});
        end

        // Throughput with ack and ready tied high: 1-byte @0, 2-byte @1..2, 1-byte @3.
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        mem[0] = 8'h35; mem[1] = 8'h92; mem[2] = 8'h7E; mem[3] = 8'h41;
        @(negedge clk);
        rst_n = 1'b0; pc_load = 1'b0; mem_ack = 1'b1; issue_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n_iss = 0;
        for (int c = 0; c < 12; c++) begin
            mem_rdata = mem[mem_addr];
            #1;
            if (issue_valid && n_iss < 3) begin
                iss_cyc[n_iss] = c;
                iss_pco[n_iss] = pc_out;
                iss_imm[n_iss] = imm;
                n_iss++;
            end
            @(negedge clk);
        end
        check("tput_count", 64'(n_iss), 64'd3);
        if (n_iss == 3) begin
            check("tput_cyc0", 64'(iss_cyc[0]), 64'd1);
            check("tput_cyc1", 64'(iss_cyc[1]), 64'd4);
            check("tput_cyc2", 64'(iss_cyc[2]), 64'd6);
            check("tput_pco1", 64'(iss_pco[1]), 64'h01);
            check("tput_imm1", 64'(iss_imm[1]), 64'h7E);
            check("tput_pco2", 64'(iss_pco[2]), 64'h03);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
